// File: rtl/target_addr_holder_pkg.sv
// Shared CPU pipeline constants and types used by the pipeline registers.
// Every stage register reads its address width and reset vector from here.
package target_addr_holder_pkg;

  localparam int CPU_ADDR_W = 32;
  localparam logic [CPU_ADDR_W-1:0] CPU_RESET_ADDR = '0;

  typedef logic [CPU_ADDR_W-1:0] cpu_addr_t;

endpackage

// File: rtl/target_addr_holder.sv
// Stage 0 -> stage 1 branch/jump target register; one-cycle latency when enabled.
// No backpressure: clk_enable low simply holds the current value; valid flags the first load.
module target_addr_holder
  import target_addr_holder_pkg::*;
#(
  parameter int                ADDR_W     = CPU_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_ADDR = CPU_RESET_ADDR[ADDR_W-1:0]
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clk_enable,
  input  logic [ADDR_W-1:0] tgt_addr_0,
  output logic [ADDR_W-1:0] tgt_addr_1,
  output logic              tgt_valid_1
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tgt_addr_1 <= RESET_ADDR;
    end else if (clk_enable) begin
      tgt_addr_1 <= tgt_addr_0;
    end
  end

  // Sticky until reset: marks that tgt_addr_1 holds a real target.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tgt_valid_1 <= 1'b0;
    end else if (clk_enable) begin
      tgt_valid_1 <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  // Shadow of the last edge; an async reset disarms it so a mid-cycle reset never trips a check.
  logic              chk_armed;
  logic              chk_en;
  logic [ADDR_W-1:0] chk_addr;
  logic [ADDR_W-1:0] chk_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chk_armed <= 1'b0;
      chk_en    <= 1'b0;
      chk_addr  <= '0;
      chk_prev  <= '0;
    end else begin
      chk_armed <= 1'b1;
      chk_en    <= clk_enable;
      chk_addr  <= tgt_addr_0;
      chk_prev  <= tgt_addr_1;
    end
  end

  always @(negedge clk) begin
    if (reset_n && chk_armed) begin
      if (chk_en) begin
        assert (tgt_addr_1 == chk_addr);
      end else begin
        assert (tgt_addr_1 == chk_prev);
      end
    end
  end
`endif

endmodule

// File: tb/tb_target_addr_holder.sv
// Directed and random checks of the stage-1 target register against hand-computed values.
module tb_target_addr_holder;

  logic        clk;
  logic        reset_n;
  logic        clk_enable;
  logic [31:0] tgt_addr_0;
  logic [31:0] tgt_addr_1;
  logic        tgt_valid_1;

  int total = 0;
  int bad   = 0;

  target_addr_holder dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clk_enable (clk_enable),
    .tgt_addr_0 (tgt_addr_0),
    .tgt_addr_1 (tgt_addr_1),
    .tgt_valid_1(tgt_valid_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset();
    tgt_addr_0 = 32'hDEAD_BEEF;
    clk_enable = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (tgt_addr_1 !== 32'h0) begin
      bad++;
      $display("FAIL reset_addr_immediate: got %h want %h", tgt_addr_1, 32'h0);
    end
    total++;
    if (tgt_valid_1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid_immediate: got %b want 0", tgt_valid_1);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (tgt_addr_1 !== 32'h0 || tgt_valid_1 !== 1'b0) begin
        bad++;
        $display("FAIL reset_held_%0d: got addr=%h valid=%b want addr=00000000 valid=0",
                 i, tgt_addr_1, tgt_valid_1);
      end
    end
    @(negedge clk);
    clk_enable = 1'b0;
    reset_n    = 1'b1;
    #1;
    total++;
    if (tgt_addr_1 !== 32'h0 || tgt_valid_1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got addr=%h valid=%b want addr=00000000 valid=0",
               tgt_addr_1, tgt_valid_1);
    end
  endtask

  task automatic test_load();
    @(negedge clk);
    clk_enable = 1'b1;
    tgt_addr_0 = 32'h1234_5678;
    @(posedge clk); #1;
    total++;
    if (tgt_addr_1 !== 32'h1234_5678) begin
      bad++;
      $display("FAIL load_addr: got %h want %h", tgt_addr_1, 32'h1234_5678);
    end
    total++;
    if (tgt_valid_1 !== 1'b1) begin
      bad++;
      $display("FAIL load_valid: got %b want 1", tgt_valid_1);
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    clk_enable = 1'b0;
    tgt_addr_0 = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (tgt_addr_1 !== 32'h1234_5678 || tgt_valid_1 !== 1'b1) begin
        bad++;
        $display("FAIL hold_%0d: got addr=%h valid=%b want addr=12345678 valid=1",
                 i, tgt_addr_1, tgt_valid_1);
      end
    end
    // Undefined input while disabled must not leak into the register.
    @(negedge clk);
    tgt_addr_0 = 'x;
    @(posedge clk); #1;
    total++;
    if (tgt_addr_1 !== 32'h1234_5678) begin
      bad++;
      $display("FAIL hold_x_input: got %h want %h", tgt_addr_1, 32'h1234_5678);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vec [4];
    vec[0] = 32'hFFFF_FFFF;
    vec[1] = 32'h0000_0000;
    vec[2] = 32'h8000_0001;
    vec[3] = 32'h0000_0003;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      clk_enable = 1'b1;
      tgt_addr_0 = vec[i];
      @(posedge clk); #1;
      total++;
      if (tgt_addr_1 !== vec[i]) begin
        bad++;
        $display("FAIL back_to_back_%0d: got %h want %h", i, tgt_addr_1, vec[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_addr;
    time         t0;
    exp_addr = 32'h0000_0003;
    t0 = $time;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      clk_enable = 1'($urandom_range(0, 1));
      tgt_addr_0 = $urandom;
      if (clk_enable) exp_addr = tgt_addr_0;
      @(posedge clk); #1;
      total++;
      if (tgt_addr_1 !== exp_addr || tgt_valid_1 !== 1'b1) begin
        bad++;
        $display("FAIL random_%0d: got addr=%h valid=%b want addr=%h valid=1",
                 i, tgt_addr_1, tgt_valid_1, exp_addr);
      end
    end
    total++;
    if ($time - t0 > 220 * 5) begin
      bad++;
      $display("FAIL random_timeout: took %0t time units, limit %0d", $time - t0, 220 * 5);
    end
  endtask

  task automatic test_midop_reset();
    @(negedge clk);
    clk_enable = 1'b1;
    tgt_addr_0 = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    total++;
    if (tgt_addr_1 !== 32'hA5A5_A5A5) begin
      bad++;
      $display("FAIL midop_preload: got %h want %h", tgt_addr_1, 32'hA5A5_A5A5);
    end
    #1;
    reset_n    = 1'b0;
    tgt_addr_0 = 32'h0000_0077;
    #1;
    total++;
    if (tgt_addr_1 !== 32'h0 || tgt_valid_1 !== 1'b0) begin
      bad++;
      $display("FAIL midop_async_reset: got addr=%h valid=%b want addr=00000000 valid=0",
               tgt_addr_1, tgt_valid_1);
    end
    // Enabled edge during reset must be ignored.
    @(posedge clk); #1;
    total++;
    if (tgt_addr_1 !== 32'h0 || tgt_valid_1 !== 1'b0) begin
      bad++;
      $display("FAIL midop_reset_ignores_load: got addr=%h valid=%b want addr=00000000 valid=0",
               tgt_addr_1, tgt_valid_1);
    end
    @(negedge clk);
    reset_n    = 1'b1;
    tgt_addr_0 = 32'h0000_0004;
    @(posedge clk); #1;
    total++;
    if (tgt_addr_1 !== 32'h0000_0004 || tgt_valid_1 !== 1'b1) begin
      bad++;
      $display("FAIL midop_reload: got addr=%h valid=%b want addr=00000004 valid=1",
               tgt_addr_1, tgt_valid_1);
    end
  endtask

  initial begin
    reset_n    = 1'b1;
    clk_enable = 1'b0;
    tgt_addr_0 = '0;
    test_reset();
    test_load();
    test_hold();
    test_back_to_back();
    test_random();
    test_midop_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
